// File: rtl/ldr_pkg.sv
// ldr_pkg: definitions shared by the weight burst loader and the weight cache clients.
// Holds the default handshake widths and the loader FSM state encoding.
package ldr_pkg;

   localparam int LDR_ADDR_W = 19;
   localparam int LDR_CNT_W  = 11;
   localparam int LDR_DATA_W = 128;

   typedef enum logic [1:0] {
      LDR_IDLE  = 2'd0,
      LDR_GRANT = 2'd1,
      LDR_ISSUE = 2'd2,
      LDR_DRAIN = 2'd3
   } ldr_state_e;

endpackage

// File: rtl/ldr_rr_arbiter.sv
// ldr_rr_arbiter: combinational round-robin pick.
// Ports:
//   req        in  NUM_CLIENTS  request vector
//   ptr        in  PTR_W        first client to consider (0..NUM_CLIENTS-1)
//   any_req    out 1            at least one request present
//   win_onehot out NUM_CLIENTS  one-hot winner (0 when no request)
//   win_idx    out PTR_W        index of the winner
module ldr_rr_arbiter
   import ldr_pkg::*;
#(
   parameter int NUM_CLIENTS = 3,
   parameter int PTR_W       = 2
) (
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [PTR_W-1:0]       ptr,
   output logic                   any_req,
   output logic [NUM_CLIENTS-1:0] win_onehot,
   output logic [PTR_W-1:0]       win_idx
);

   logic [2*NUM_CLIENTS-1:0] req2;
   logic [NUM_CLIENTS-1:0]   rot;
   logic [PTR_W-1:0]         off;
   logic [PTR_W:0]           sum;

   // Rotate so the pointer lands on bit 0, take the lowest set bit, then un-rotate.
   always_comb begin
      req2    = {req, req};
      rot     = req2[ptr +: NUM_CLIENTS];
      any_req = |req;
      off     = '0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         if (rot[k]) off = PTR_W'(k);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (PTR_W + 1)'(NUM_CLIENTS)) sum = sum - (PTR_W + 1)'(NUM_CLIENTS);
      win_idx    = sum[PTR_W-1:0];
      win_onehot = any_req ? (NUM_CLIENTS'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/weight_burst_loader.sv
// weight_burst_loader: serves ldr_* burst reads from the weight caches out of the
// single-port weight SRAM. One burst at a time, round-robin between clients.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ldr_req        per-client request level
//   ldr_grant      one-hot single-cycle grant
//   ldr_base_addr  flattened per-client base word address
//   ldr_count      flattened per-client burst length (0 allowed)
//   ldr_valid      one-hot beat strobe to the granted client
//   ldr_data       shared beat data, holds between beats
//   ldr_done       one-hot end-of-burst pulse, coincident with the last beat
//   mem_en/addr    SRAM read request; mem_en only ever high while mem_gnt is high
//   mem_gnt        SRAM port available this cycle
//   mem_rdata      SRAM data, RD_LAT cycles after an accepted mem_en
module weight_burst_loader
   import ldr_pkg::*;
#(
   parameter int NUM_CLIENTS = 3,
   parameter int ADDR_W      = LDR_ADDR_W,
   parameter int CNT_W       = LDR_CNT_W,
   parameter int DATA_W      = LDR_DATA_W,
   parameter int RD_LAT      = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CLIENTS-1:0]        ldr_req,
   output logic [NUM_CLIENTS-1:0]        ldr_grant,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] ldr_base_addr,
   input  logic [NUM_CLIENTS*CNT_W-1:0]  ldr_count,
   output logic [NUM_CLIENTS-1:0]        ldr_valid,
   output logic [DATA_W-1:0]             ldr_data,
   output logic [NUM_CLIENTS-1:0]        ldr_done,
   output logic                          mem_en,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic                          mem_gnt,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   ldr_state_e             state, state_nxt;
   logic [PTR_W-1:0]       rr_ptr, idx_r, win_idx;
   logic [NUM_CLIENTS-1:0] win_onehot, idx_oh;
   logic                   any_req;
   logic [ADDR_W-1:0]      addr_r;
   logic [CNT_W-1:0]       cnt_r, issue_cnt;
   logic                   last_issue, lst_p0, zero_p;
   logic [RD_LAT:1]        vld_p, lst_p;

   ldr_rr_arbiter #(
      .NUM_CLIENTS(NUM_CLIENTS),
      .PTR_W      (PTR_W)
   ) u_arb (
      .req       (ldr_req),
      .ptr       (rr_ptr),
      .any_req   (any_req),
      .win_onehot(win_onehot),
      .win_idx   (win_idx)
   );

   assign idx_oh   = NUM_CLIENTS'(1) << idx_r;
   assign mem_addr = addr_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LDR_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LDR_IDLE:  if (any_req) state_nxt = LDR_GRANT;
         LDR_GRANT: state_nxt = (cnt_r == '0) ? LDR_DRAIN : LDR_ISSUE;
         LDR_ISSUE: if (lst_p0) state_nxt = LDR_DRAIN;
         LDR_DRAIN: if (|ldr_done) state_nxt = LDR_IDLE;
         default:   state_nxt = LDR_IDLE;
      endcase
   end

   // Stage p0: read issue. mem_en is qualified by mem_gnt in the same cycle so a
   // withheld port never sees a request and the beat counter simply stalls.
   always_comb begin
      mem_en     = (state == LDR_ISSUE) && mem_gnt;
      last_issue = (issue_cnt + CNT_W'(1)) == cnt_r;
      lst_p0     = mem_en && last_issue;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         idx_r     <= '0;
         addr_r    <= '0;
         cnt_r     <= '0;
         issue_cnt <= '0;
         zero_p    <= 1'b0;
         vld_p     <= '0;
         lst_p     <= '0;
         ldr_grant <= '0;
         ldr_valid <= '0;
         ldr_done  <= '0;
         ldr_data  <= '0;
      end else begin
         ldr_grant <= '0;
         if (state == LDR_IDLE && any_req) begin
            idx_r     <= win_idx;
            addr_r    <= ldr_base_addr[win_idx*ADDR_W +: ADDR_W];
            cnt_r     <= ldr_count[win_idx*CNT_W +: CNT_W];
            issue_cnt <= '0;
            ldr_grant <= win_onehot;
         end
         if (state == LDR_GRANT) begin
            rr_ptr <= (idx_r == PTR_W'(NUM_CLIENTS - 1)) ? '0 : idx_r + PTR_W'(1);
         end
         if (mem_en) begin
            addr_r    <= addr_r + ADDR_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
         end
         // Empty burst: no beat ever travels the pipe, so done is produced from the
         // grant cycle directly, two cycles after the grant pulse.
         zero_p <= (state == LDR_GRANT) && (cnt_r == '0);

         // Stages p1..pRD_LAT: {valid,last} track the SRAM read latency.
         vld_p[1] <= mem_en;
         lst_p[1] <= lst_p0;
         for (int k = RD_LAT; k >= 2; k--) begin
            vld_p[k] <= vld_p[k-1];
            lst_p[k] <= lst_p[k-1];
         end

         // Output stage: register the SRAM word alongside its strobes.
         ldr_valid <= '0;
         ldr_done  <= '0;
         if (vld_p[RD_LAT]) begin
            ldr_valid <= idx_oh;
            ldr_data  <= mem_rdata;
            if (lst_p[RD_LAT]) ldr_done <= idx_oh;
         end
         if (zero_p) ldr_done <= idx_oh;
      end
   end

endmodule
